// File: rtl/ped_pkg.sv
// Shared types and constants for the pedestrian crossing controller.
package ped_pkg;

  typedef enum logic [2:0] {
    LT_GREEN  = 3'b001,
    LT_YELLOW = 3'b010,
    LT_RED    = 3'b100
  } light_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PENDING,
    ST_WALK,
    ST_CLEAR
  } ped_state_t;

  localparam int N = 0;
  localparam int E = 1;
  localparam int S = 2;
  localparam int W = 3;

  localparam int TMR_W = 16;

  // Anything other than a clean red or yellow is unsafe while pedestrians may be on the road.
  function automatic logic light_unsafe(input logic [2:0] code);
    return !((code == LT_RED) || (code == LT_YELLOW));
  endfunction

endpackage

// File: rtl/ped_debounce.sv
// Button conditioner: 2-flop synchronizer, tick-based stability counter, one-cycle press pulse.
module ped_debounce
  import ped_pkg::*;
#(
  parameter int DEB_TICKS = 20
) (
  input  logic clk_in,
  input  logic rstn,
  input  logic tick,
  input  logic btn_raw,
  output logic press
);

  localparam logic [TMR_W:0] DEB_LIM = (TMR_W + 1)'(DEB_TICKS);

  logic             sync_p0;
  logic             sync_p1;
  logic             deb_q;
  logic [TMR_W-1:0] cnt_q;

  function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk_in or posedge rstn) begin
    if (rstn) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      deb_q   <= 1'b0;
      cnt_q   <= '0;
      press   <= 1'b0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      // Counter measures how long the synchronized level has disagreed with the debounced one.
      if (sync_p1 == deb_q) begin
        cnt_q <= '0;
      end else if (tick) begin
        if (({1'b0, cnt_q} + 1'b1) >= DEB_LIM) begin
          deb_q <= sync_p1;
          cnt_q <= '0;
          press <= sync_p1;
        end else begin
          cnt_q <= sat_inc(cnt_q);
        end
      end
    end
  end

endmodule

// File: rtl/ped_crossing_ctrl.sv
// Four-crossing pedestrian signal controller slaved to the vehicle light codes.
// Optional macro PED_CONFLICT_ERR_EN enables the sticky conflict_err flag.
module ped_crossing_ctrl
  import ped_pkg::*;
#(
  parameter int TICK_DIV    = 100000,
  parameter int DEB_TICKS   = 20,
  parameter int WALK_TICKS  = 4000,
  parameter int CLEAR_TICKS = 3000,
  parameter int FLASH_TICKS = 250
) (
  input  logic       clk_in,
  input  logic       rstn,
  input  logic [3:0] ped_btn,
  input  logic [2:0] north,
  input  logic [2:0] east,
  input  logic [2:0] south,
  input  logic [2:0] west,
  output logic [3:0] walk,
  output logic [3:0] dont_walk,
  output logic [3:0] req_pending,
  output logic       conflict_err
);

  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(TICK_DIV - 1);
  localparam logic [TMR_W:0]   WALK_LIM  = (TMR_W + 1)'(WALK_TICKS);
  localparam logic [TMR_W:0]   CLEAR_LIM = (TMR_W + 1)'(CLEAR_TICKS);
  localparam logic [TMR_W:0]   FLASH_LIM = (TMR_W + 1)'(FLASH_TICKS);

  logic [PRE_W-1:0] pre_q;
  logic             tick;
  logic [3:0]       press;
  logic [2:0]       light [4];
  logic [2:0]       light_prev_q [4];
  ped_state_t       state_q [4];
  logic [TMR_W-1:0] tmr_q [4];
  logic [TMR_W-1:0] flash_cnt_q [4];
  logic [3:0]       flash_q;
  logic [3:0]       again_q;
  logic [3:0]       forced;
  logic [3:0]       red_onset;

  function automatic logic [TMR_W-1:0] sat_inc(input logic [TMR_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign light[N] = north;
  assign light[E] = east;
  assign light[S] = south;
  assign light[W] = west;

  assign tick = (pre_q == PRE_LAST);

  always_ff @(posedge clk_in or posedge rstn) begin
    if (rstn) begin
      pre_q <= '0;
    end else if (tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_deb
    ped_debounce #(.DEB_TICKS(DEB_TICKS)) u_deb (
      .clk_in (clk_in),
      .rstn   (rstn),
      .tick   (tick),
      .btn_raw(ped_btn[g]),
      .press  (press[g])
    );
  end

  always_comb begin
    forced    = '0;
    red_onset = '0;
    for (int i = 0; i < 4; i++) begin
      forced[i]    = ((state_q[i] == ST_WALK) || (state_q[i] == ST_CLEAR)) && light_unsafe(light[i]);
      red_onset[i] = (light[i] == LT_RED) && (light_prev_q[i] != LT_RED);
    end
  end

  // Per-crossing FSMs; outputs are decoded from the current state so they trail it by one cycle.
  always_ff @(posedge clk_in or posedge rstn) begin
    if (rstn) begin
      for (int i = 0; i < 4; i++) begin
        state_q[i]      <= ST_IDLE;
        tmr_q[i]        <= '0;
        flash_cnt_q[i]  <= '0;
        light_prev_q[i] <= LT_RED;
      end
      flash_q     <= '1;
      again_q     <= '0;
      walk        <= '0;
      dont_walk   <= '1;
      req_pending <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        light_prev_q[i] <= light[i];
        walk[i]         <= (state_q[i] == ST_WALK);
        req_pending[i]  <= (state_q[i] == ST_PENDING);
        dont_walk[i]    <= (state_q[i] == ST_IDLE) || (state_q[i] == ST_PENDING) ||
                           ((state_q[i] == ST_CLEAR) && flash_q[i]);
        if (forced[i]) begin
          state_q[i] <= ST_IDLE;
          again_q[i] <= 1'b0;
        end else begin
          case (state_q[i])
            ST_IDLE: begin
              if (press[i]) state_q[i] <= ST_PENDING;
            end
            ST_PENDING: begin
              if (red_onset[i]) begin
                state_q[i] <= ST_WALK;
                tmr_q[i]   <= '0;
              end
            end
            ST_WALK: begin
              if ((light[i] == LT_YELLOW) ||
                  (tick && (({1'b0, tmr_q[i]} + 1'b1) >= WALK_LIM))) begin
                state_q[i]     <= ST_CLEAR;
                tmr_q[i]       <= '0;
                flash_cnt_q[i] <= '0;
                flash_q[i]     <= 1'b1;
                again_q[i]     <= 1'b0;
              end else if (tick) begin
                tmr_q[i] <= sat_inc(tmr_q[i]);
              end
            end
            ST_CLEAR: begin
              if (press[i]) again_q[i] <= 1'b1;
              if (tick) begin
                if (({1'b0, flash_cnt_q[i]} + 1'b1) >= FLASH_LIM) begin
                  flash_q[i]     <= ~flash_q[i];
                  flash_cnt_q[i] <= '0;
                end else begin
                  flash_cnt_q[i] <= sat_inc(flash_cnt_q[i]);
                end
                if (({1'b0, tmr_q[i]} + 1'b1) >= CLEAR_LIM) begin
                  state_q[i] <= (again_q[i] || press[i]) ? ST_PENDING : ST_IDLE;
                  again_q[i] <= 1'b0;
                end else begin
                  tmr_q[i] <= sat_inc(tmr_q[i]);
                end
              end
            end
            default: state_q[i] <= ST_IDLE;
          endcase
        end
      end
    end
  end

`ifdef PED_CONFLICT_ERR_EN
  always_ff @(posedge clk_in or posedge rstn) begin
    if (rstn) begin
      conflict_err <= 1'b0;
    end else if (|forced) begin
      conflict_err <= 1'b1;
    end
  end
`else
  assign conflict_err = 1'b0;
`endif

endmodule

// File: tb/tb_ped_crossing_ctrl.sv
// Directed bench for ped_crossing_ctrl with a per-cycle reference model (PED_CONFLICT_ERR_EN aware).
module tb_ped_crossing_ctrl;

  localparam int TICK_DIV    = 1;
  localparam int DEB_TICKS   = 2;
  localparam int WALK_TICKS  = 8;
  localparam int CLEAR_TICKS = 6;
  localparam int FLASH_TICKS = 2;

`ifdef PED_CONFLICT_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam logic [2:0] C_GRN = 3'b001;
  localparam logic [2:0] C_YEL = 3'b010;
  localparam logic [2:0] C_RED = 3'b100;

  localparam int M_IDLE = 0, M_PEND = 1, M_WALK = 2, M_CLEAR = 3;

  logic       clk_in = 1'b0;
  logic       rstn   = 1'b0;
  logic [3:0] ped_btn = 4'b0;
  logic [2:0] lt [4];
  logic [3:0] walk, dont_walk, req_pending;
  logic       conflict_err;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  ped_crossing_ctrl #(
    .TICK_DIV(TICK_DIV), .DEB_TICKS(DEB_TICKS), .WALK_TICKS(WALK_TICKS),
    .CLEAR_TICKS(CLEAR_TICKS), .FLASH_TICKS(FLASH_TICKS)
  ) dut (
    .clk_in(clk_in), .rstn(rstn), .ped_btn(ped_btn),
    .north(lt[0]), .east(lt[1]), .south(lt[2]), .west(lt[3]),
    .walk(walk), .dont_walk(dont_walk), .req_pending(req_pending),
    .conflict_err(conflict_err)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: state per crossing, remaining walk time, elapsed clearance time,
  // debounce judged from a history of synchronized samples.
  int         m_state [4];
  int         m_rem [4];
  int         m_el [4];
  bit         m_again [4];
  bit         m_s1 [4], m_s2 [4], m_deb [4], m_press [4];
  bit [15:0]  m_hist [4];
  logic [2:0] m_prev [4];
  bit [3:0]   mw, mdw, mrp;
  bit         merr;

  localparam bit [15:0] HMASK = 16'((1 << DEB_TICKS) - 1);

  always @(posedge clk_in or posedge rstn) begin
    if (rstn) begin
      for (int i = 0; i < 4; i++) begin
        m_state[i] = M_IDLE; m_rem[i] = 0; m_el[i] = 0; m_again[i] = 0;
        m_s1[i] = 0; m_s2[i] = 0; m_deb[i] = 0; m_press[i] = 0; m_hist[i] = '0;
        m_prev[i] = C_RED;
      end
      mw = '0; mdw = '1; mrp = '0; merr = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        bit bad, onset;
        mw[i]  = (m_state[i] == M_WALK);
        mrp[i] = (m_state[i] == M_PEND);
        if (m_state[i] == M_CLEAR) mdw[i] = (((m_el[i] / FLASH_TICKS) % 2) == 0);
        else                       mdw[i] = (m_state[i] != M_WALK);
        bad   = !(lt[i] == C_RED || lt[i] == C_YEL);
        onset = (lt[i] == C_RED) && (m_prev[i] != C_RED);
        if ((m_state[i] == M_WALK || m_state[i] == M_CLEAR) && bad) begin
          m_state[i] = M_IDLE;
          if (ERR_EN) merr = 1;
        end else if (m_state[i] == M_IDLE) begin
          if (m_press[i]) m_state[i] = M_PEND;
        end else if (m_state[i] == M_PEND) begin
          if (onset) begin m_state[i] = M_WALK; m_rem[i] = WALK_TICKS; end
        end else if (m_state[i] == M_WALK) begin
          m_rem[i] = m_rem[i] - 1;
          if (lt[i] == C_YEL || m_rem[i] == 0) begin
            m_state[i] = M_CLEAR; m_el[i] = 0; m_again[i] = 0;
          end
        end else begin
          if (m_press[i]) m_again[i] = 1;
          m_el[i] = m_el[i] + 1;
          if (m_el[i] == CLEAR_TICKS) m_state[i] = m_again[i] ? M_PEND : M_IDLE;
        end
        m_prev[i]  = lt[i];
        m_press[i] = 0;
        m_hist[i]  = {m_hist[i][14:0], m_s2[i]};
        if ((m_hist[i] & HMASK) == (m_deb[i] ? 16'h0 : HMASK)) begin
          m_deb[i]   = !m_deb[i];
          m_press[i] = m_deb[i];
        end
        m_s2[i] = m_s1[i];
        m_s1[i] = ped_btn[i];
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #2;
  endtask

  initial begin
    int        wcnt;
    int        ndw;
    bit        seen;
    bit [5:0]  pat;
    lt[0] = C_GRN; lt[1] = C_RED; lt[2] = C_RED; lt[3] = C_RED;
    #1 rstn = 1'b1;
    chk_en = 1'b1;
    #1;
    chk("rst_walk", 32'(walk), 32'h0);
    chk("rst_dont_walk", 32'(dont_walk), 32'hF);
    chk("rst_req_pending", 32'(req_pending), 32'h0);
    chk("rst_conflict_err", 32'(conflict_err), 32'h0);

    fork
      forever begin
        @(negedge clk_in);
        if (chk_en) begin
          chk("model_walk", 32'(walk), 32'(mw));
          chk("model_dont_walk", 32'(dont_walk), 32'(mdw));
          chk("model_req_pending", 32'(req_pending), 32'(mrp));
          chk("model_conflict_err", 32'(conflict_err), 32'(merr));
        end
      end
    join_none

    step(3);
    rstn = 1'b0;
    step(2);

    // North: press on green, yellow then red onset, full walk and clearance.
    ped_btn[0] = 1'b1; step(4); ped_btn[0] = 1'b0; step(6);
    chk("n_pending", 32'(req_pending[0]), 32'h1);
    chk("n_no_walk_yet", 32'(walk[0]), 32'h0);
    lt[0] = C_YEL; step(3);
    lt[0] = C_RED;
    wcnt = 0; ndw = 0; seen = 0; pat = '0;
    for (int k = 0; k < 30; k++) begin
      step(1);
      if (walk[0]) begin wcnt++; seen = 1; end
      else if (seen && ndw < 6) begin pat = {pat[4:0], dont_walk[0]}; ndw++; end
    end
    chk("n_walk_len", 32'(wcnt), 32'd8);
    chk("n_flash_pattern", 32'(pat), 32'b110011);
    chk("n_idle_dont_walk", 32'(dont_walk[0]), 32'h1);
    chk("n_idle_pending", 32'(req_pending[0]), 32'h0);

    // East: glitch rejected, held press accepted, then conflict during walk.
    ped_btn[1] = 1'b1; step(1); ped_btn[1] = 1'b0; step(10);
    chk("e_glitch", 32'(req_pending[1]), 32'h0);
    ped_btn[1] = 1'b1; step(3); ped_btn[1] = 1'b0; step(8);
    chk("e_hold", 32'(req_pending[1]), 32'h1);
    lt[1] = C_YEL; step(2); lt[1] = C_RED; step(3);
    chk("e_walk", 32'(walk[1]), 32'h1);
    lt[1] = C_GRN; step(1);
    chk("e_conflict", 32'(conflict_err), 32'(ERR_EN));
    step(1);
    chk("e_walk_dropped", 32'(walk[1]), 32'h0);
    chk("e_dont_walk", 32'(dont_walk[1]), 32'h1);
    lt[1] = C_RED; step(10);
    chk("e_conflict_sticky", 32'(conflict_err), 32'(ERR_EN));

    // South: press while already red waits for the next red onset.
    ped_btn[2] = 1'b1; step(4); ped_btn[2] = 1'b0; step(8);
    chk("s_pending", 32'(req_pending[2]), 32'h1);
    step(4);
    chk("s_no_walk_on_red", 32'(walk[2]), 32'h0);
    lt[2] = C_GRN; step(2); lt[2] = C_RED; step(3);
    chk("s_walk", 32'(walk[2]), 32'h1);
    lt[2] = 3'b110; step(2);
    chk("s_bad_code_exit", 32'(walk[2]), 32'h0);
    lt[2] = C_RED; step(2);

    // West: reset in the middle of a walk, then a normal cycle afterwards.
    lt[3] = C_GRN;
    ped_btn[3] = 1'b1; step(4); ped_btn[3] = 1'b0; step(6);
    lt[3] = C_RED; step(3);
    chk("w_walk", 32'(walk[3]), 32'h1);
    rstn = 1'b1;
    #1;
    chk("w_rst_walk", 32'(walk), 32'h0);
    chk("w_rst_dont_walk", 32'(dont_walk), 32'hF);
    chk("w_rst_conflict", 32'(conflict_err), 32'h0);
    step(2);
    rstn = 1'b0;
    lt[3] = C_GRN; step(2);
    ped_btn[3] = 1'b1; step(4); ped_btn[3] = 1'b0; step(6);
    chk("w_pending_after_rst", 32'(req_pending[3]), 32'h1);
    lt[3] = C_RED; step(3);
    chk("w_walk_after_rst", 32'(walk[3]), 32'h1);
    step(20);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
